// File: rtl/div_rate_if.sv
// div_rate_if: handshake/status bundle between configuration logic and the
// divided-clock sequencer.
//   run       : level, 1 = produce output, 0 = stop at next period end
//   req_valid : rate-change request present
//   req_half  : requested half-period in clk_in cycles (0 is rejected)
//   req_ready : sequencer can accept a request this cycle
//   req_ack   : one-cycle pulse when an accepted ratio takes effect
//   req_err   : one-cycle pulse when a zero half-period is rejected
//   clk_out   : divided output clock
//   tick      : high in the cycle right after clk_out rose
//   busy      : sequencer is RUN, PEND or STOP
interface div_rate_if #(
  parameter int DIV_W = 16
) ();
  logic             run;
  logic             req_valid;
  logic [DIV_W-1:0] req_half;
  logic             req_ready;
  logic             req_ack;
  logic             req_err;
  logic             clk_out;
  logic             tick;
  logic             busy;

  modport master (
    output run, req_valid, req_half,
    input  req_ready, req_ack, req_err, clk_out, tick, busy
  );

  modport slave (
    input  run, req_valid, req_half,
    output req_ready, req_ack, req_err, clk_out, tick, busy
  );
endinterface

// File: rtl/div_rate_sequencer.sv
// div_rate_sequencer: run-time controlled clock divider. Produces clk_out
// (low for half cycles, then high for half cycles) and a tick strobe after
// each rising edge. Ratio changes arrive over a valid/ready handshake and are
// applied only at a period end (clk_out 1->0), so no runt/stretched phases.
// Ports:
//   clk_in : the single clock, rising edge
//   nreset : synchronous, active-high reset
//   bus    : div_rate_if slave (run, request handshake, clk_out/tick/busy)
module div_rate_sequencer #(
  parameter int SYS_CLK     = 50000000,
  parameter int DESIRED_CLK = 25000000,
  parameter int DIV_W       = 16
) (
  input logic      clk_in,
  input logic      nreset,
  div_rate_if.slave bus
);

  localparam int HALF_DEF = SYS_CLK / (2 * DESIRED_CLK);
  localparam logic [DIV_W-1:0] HALF_DEF_W = DIV_W'(HALF_DEF);

  generate
    if (HALF_DEF == 0) begin : g_bad_half
      $error("div_rate_sequencer: default half-period SYS_CLK/(2*DESIRED_CLK) is 0");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic ready, accept, req_ok, wrap, per_end;

  assign ready   = (state_q == S_IDLE) || (state_q == S_RUN);
  assign accept  = bus.req_valid && ready;
  assign req_ok  = accept && (bus.req_half != '0);
  assign wrap    = (cnt_q == half_q - DIV_W'(1));
  // Period end: the high phase is finishing, clk_out goes 1 -> 0 this edge.
  assign per_end = wrap && clk_out_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    pend_d    = pend_q;
    clk_out_d = clk_out_q;
    ack_d     = 1'b0;
    err_d     = accept && (bus.req_half == '0);

    // Free-running divider in every active state.
    if (state_q != S_IDLE) begin
      if (wrap) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        if (req_ok) begin
          half_d = bus.req_half;
          ack_d  = 1'b1;
        end
        if (bus.run) state_d = S_RUN;
      end
      S_RUN: begin
        // A request wins over a stop; PEND resolves the stop at period end.
        if (req_ok) begin
          pend_d  = bus.req_half;
          state_d = S_PEND;
        end else if (!bus.run) begin
          // Dropping run exactly on a period end leaves clk_out low already.
          state_d = per_end ? S_IDLE : S_STOP;
        end
      end
      S_PEND: begin
        if (per_end) begin
          half_d  = pend_q;
          cnt_d   = '0;
          ack_d   = 1'b1;
          state_d = bus.run ? S_RUN : S_IDLE;
        end
      end
      S_STOP: begin
        if (bus.run)      state_d = S_RUN;
        else if (per_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    tick_d = ~clk_out_q & clk_out_d;
  end

  always_ff @(posedge clk_in) begin
    if (nreset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      half_q    <= HALF_DEF_W;
      pend_q    <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.req_ack   = ack_q;
  assign bus.req_err   = err_q;
  assign bus.clk_out   = clk_out_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_rate_sequencer.sv
// Bench for div_rate_sequencer: directed stimulus pushes expected
// tick/ack/err events (kind + cycle) into a scoreboard; a negedge monitor
// matches every observed pulse against it. Level checks are done inline.
module tb_div_rate_sequencer;
  localparam int DIV_W = 16;

  logic clk_in = 1'b0;
  logic nreset;

  div_rate_if #(.DIV_W(DIV_W)) bus ();

  div_rate_sequencer #(
    .SYS_CLK(50000000), .DESIRED_CLK(25000000), .DIV_W(DIV_W)
  ) dut (
    .clk_in(clk_in),
    .nreset(nreset),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef enum int {EV_TICK, EV_ACK, EV_ERR} ev_t;
  typedef struct { ev_t kind; int cyc; } exp_t;
  exp_t exp_q[$];

  int passed = 0;
  int total  = 0;

  function automatic void expect_ev(ev_t k, int c);
    exp_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endfunction

  task automatic match(ev_t k);
    int idx = -1;
    total++;
    foreach (exp_q[i])
      if (idx < 0 && exp_q[i].kind == k && exp_q[i].cyc == cyc) idx = i;
    if (idx >= 0) begin
      exp_q.delete(idx);
      passed++;
    end else
      $display("FAIL event_%s: observed at cycle %0d, no such event expected", k.name(), cyc);
  endtask

  always @(negedge clk_in) begin
    if (bus.tick    === 1'b1) match(EV_TICK);
    if (bus.req_ack === 1'b1) match(EV_ACK);
    if (bus.req_err === 1'b1) match(EV_ERR);
  end

  task automatic chk(string name, logic act, logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %b, want %b", name, cyc, act, exp);
  endtask

  // Advance to the negedge that follows posedge number c.
  task automatic at(int c);
    do @(negedge clk_in); while (cyc < c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nreset = 1'b1;
    bus.run = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_half = '0;

    // Reset state after two reset edges.
    at(2);
    chk("rst_clk_out", bus.clk_out, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_ack", bus.req_ack, 1'b0);
    chk("rst_tick", bus.tick, 1'b0);
    nreset = 1'b0;
    bus.run = 1'b1;                       // RUN at edge 3, half=1
    for (int i = 0; i < 4; i++) expect_ev(EV_TICK, 4 + 2*i);
    at(5);
    chk("def_busy", bus.busy, 1'b1);
    chk("def_clk_low", bus.clk_out, 1'b0);
    at(9);
    bus.run = 1'b0;                       // stop sampled on rise at 10
    at(11);
    chk("def_stop_busy", bus.busy, 1'b0);
    chk("def_stop_clk", bus.clk_out, 1'b0);

    // Load half=3 in IDLE, start, then change to 5 mid high phase.
    at(12);
    bus.req_valid = 1'b1; bus.req_half = 16'd3;
    expect_ev(EV_ACK, 13);
    at(13);
    bus.req_valid = 1'b0;
    at(14);
    bus.run = 1'b1;                       // RUN at 15 -> rise at 18
    expect_ev(EV_TICK, 18);
    at(19);
    bus.req_valid = 1'b1; bus.req_half = 16'd5;
    expect_ev(EV_ACK, 21);
    expect_ev(EV_TICK, 26);
    expect_ev(EV_TICK, 36);
    at(20);
    bus.req_valid = 1'b0;
    chk("pend_ready", bus.req_ready, 1'b0);
    chk("old_high", bus.clk_out, 1'b1);
    at(21);
    chk("applied_ready", bus.req_ready, 1'b1);
    chk("old_high_end", bus.clk_out, 1'b0);
    at(25);
    chk("new_low5", bus.clk_out, 1'b0);

    // Zero request is rejected without disturbing the waveform.
    at(27);
    bus.req_valid = 1'b1; bus.req_half = '0;
    expect_ev(EV_ERR, 28);
    at(28);
    bus.req_valid = 1'b0;
    chk("err_high", bus.clk_out, 1'b1);
    at(31);
    chk("err_fall31", bus.clk_out, 1'b0);

    // Request plus run=0: new ratio applied, ack, then IDLE.
    at(37);
    bus.req_valid = 1'b1; bus.req_half = 16'd4; bus.run = 1'b0;
    expect_ev(EV_ACK, 41);
    at(38);
    bus.req_valid = 1'b0;
    chk("rs_ready", bus.req_ready, 1'b0);
    at(40);
    chk("rs_busy", bus.busy, 1'b1);
    chk("rs_high", bus.clk_out, 1'b1);
    at(41);
    chk("rs_idle", bus.busy, 1'b0);
    chk("rs_clk", bus.clk_out, 1'b0);

    // Clean stop mid high phase (half=4) and restart.
    at(42);
    bus.run = 1'b1;                       // RUN at 43 -> rise at 47
    expect_ev(EV_TICK, 47);
    at(48);
    bus.run = 1'b0;
    at(50);
    chk("stop_high", bus.clk_out, 1'b1);
    chk("stop_busy", bus.busy, 1'b1);
    at(51);
    chk("stop_clk0", bus.clk_out, 1'b0);
    chk("stop_idle", bus.busy, 1'b0);
    at(52);
    bus.run = 1'b1;                       // RUN at 53 -> rise at 57
    expect_ev(EV_TICK, 57);
    expect_ev(EV_TICK, 65);
    at(56);
    chk("restart_low", bus.clk_out, 1'b0);

    // Request on the period-end edge 61: applied at the next end (69).
    at(60);
    bus.req_valid = 1'b1; bus.req_half = 16'd2;
    expect_ev(EV_ACK, 69);
    expect_ev(EV_TICK, 71);
    expect_ev(EV_TICK, 75);
    at(61);
    bus.req_valid = 1'b0;
    chk("pe_ready61", bus.req_ready, 1'b0);
    chk("pe_clk61", bus.clk_out, 1'b0);
    at(68);
    chk("pe_ready68", bus.req_ready, 1'b0);
    at(69);
    chk("pe_ready69", bus.req_ready, 1'b1);

    // Reset while PEND: request dropped, no ack, half back to default 1.
    at(75);
    bus.req_valid = 1'b1; bus.req_half = 16'd6;
    at(76);
    bus.req_valid = 1'b0;
    chk("rp_ready", bus.req_ready, 1'b0);
    nreset = 1'b1;
    at(77);
    nreset = 1'b0;
    chk("rp_clk", bus.clk_out, 1'b0);
    chk("rp_busy", bus.busy, 1'b0);
    chk("rp_ready_idle", bus.req_ready, 1'b1);
    chk("rp_no_ack", bus.req_ack, 1'b0);
    expect_ev(EV_TICK, 79);               // run still 1: RUN at 78, half=1
    expect_ev(EV_TICK, 81);
    at(80);
    bus.run = 1'b0;
    at(82);
    chk("end_busy", bus.busy, 1'b0);
    chk("end_clk", bus.clk_out, 1'b0);

    at(90);
    foreach (exp_q[i])
      $display("FAIL missing_%s: expected at cycle %0d, never observed", exp_q[i].kind.name(), exp_q[i].cyc);
    total++;
    if (exp_q.size() == 0) passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/div_rate_sequencer.md
# div_rate_sequencer

Run-time controller for the system's clock divider. Produces a divided square wave `clk_out` (with a one-cycle `tick` strobe at each rising edge) from `clk_in`. Accepts divide-ratio change requests over a valid/ready handshake and applies each one only at a full output-period boundary, so `clk_out` never has a runt or stretched phase. Also sequences clean start and stop of the output. Sits between the configuration logic and every consumer of the divided clock/enable.

## Interface
- `SYS_CLK`, 50000000: input clock frequency in Hz.
- `DESIRED_CLK`, 25000000: reset/default output frequency in Hz.
  - Default half-period is `HALF_DEF = SYS_CLK/(2*DESIRED_CLK)`, integer division.
  - Elaboration error if `HALF_DEF` is 0.
- `DIV_W`, 16: width of the half-period count.

Ports:
- `clk_in` in 1: the single clock; everything is rising-edge.
- `nreset` in 1: synchronous, active-high reset (1 = reset).
- `run` in 1: level. 1 = produce output; 0 = stop at the next period end.
- `req_valid` in 1: a rate-change request is present.
- `req_half` in `DIV_W`: requested half-period in `clk_in` cycles. Valid range is 1..2^DIV_W-1.
- `req_ready` out 1: the block can accept a request this cycle.
- `req_ack` out 1: one-cycle pulse when an accepted ratio takes effect.
- `req_err` out 1: one-cycle pulse when a request is rejected (`req_half` = 0).
- `clk_out` out 1: divided output; low for `half` cycles, then high for `half` cycles.
- `tick` out 1: high for exactly the cycle in which `clk_out` has just risen.
- `busy` out 1: high when the state is RUN, PEND or STOP.

## Operation
- Registers:
  - `state`: one of IDLE, RUN, PEND, STOP.
  - `cnt`: `DIV_W` bits.
  - `half`: active half-period, `DIV_W` bits.
  - `pend`: pending half-period, `DIV_W` bits.
  - `clk_out`.
- Reset (any edge with `nreset`=1, including mid-operation):
  - state = IDLE, `cnt` = 0, `half` = `HALF_DEF`, `pend` = 0.
  - All outputs are 0 except `req_ready` = 1.
  - Any pending request is discarded, with no ack.
- Request handshake:
  - A transfer occurs on an edge where `req_valid` && `req_ready`.
  - `req_ready` = 1 in IDLE and RUN, and 0 in PEND and STOP.
  - `req_half` = 0 when transferred: no state change, and `req_err` pulses on the following cycle.
- Counting rule, in RUN, PEND and STOP:
  - If `cnt` == `half`-1: `cnt` <= 0 and `clk_out` toggles.
  - Otherwise `cnt` increments.
  - Period end is the edge where `clk_out` goes 1 -> 0.
- IDLE:
  - `clk_out` = 0 and `cnt` = 0.
  - A valid request loads `half` directly; `req_ack` pulses on the following cycle.
  - `run`=1 -> RUN on the next edge, with `cnt` = 0.
  - If a request and `run`=1 occur on the same edge, RUN starts with the new `half`.
- RUN:
  - A valid request sets `pend` and moves to PEND.
  - `run`=0 -> STOP.
  - If a request and `run`=0 occur on the same edge, go to PEND; the stop is handled from PEND.
- PEND:
  - At period end: `half` <= `pend`, `cnt` <= 0, and `req_ack` pulses on the next cycle.
  - Next state is RUN if `run`=1, else IDLE.
  - A request accepted on the same edge as a period end is applied at the next period end, not the current one.
- STOP:
  - At period end -> IDLE, so `clk_out` is left at 0.
  - If `run` returns to 1 before the period end -> RUN, with no break in the waveform.
- Output edges:
  - `clk_out` only ever toggles on a `cnt` wrap.
  - Each high and low phase lasts exactly the `half` that was active at that phase's start.

## Timing
- Start latency: `run` sampled 1 at edge E (IDLE -> RUN at E). `clk_out` rises at E+`half` and falls at E+2·`half`.
- `tick` is high in the cycle following the edge at which `clk_out` rose.
- Period is 2·`half` `clk_in` cycles, 50% duty.
  - `half` = 1: `clk_out` toggles every cycle, i.e. `clk_in`/2.
- Ratio change latency: at most one remaining output period plus one cycle until `req_ack`.
- `req_ack` and `req_err` are single-cycle pulses and never high in the same cycle.
- Stop latency: `clk_out` is 0 and `busy` is 0 within one remaining period of `run` falling.

## Test plan
- Defaults: 50 MHz / 25 MHz, `nreset` high for 2 edges then low, `run`=1 -> `clk_out` period 2 cycles, `tick` every 2nd cycle, `busy`=1, `req_ack`=0.
- Mid-period change: in RUN with `half`=3, request `req_half`=5 at `cnt`=1 of the high phase -> the current high phase still lasts 3 cycles. Then `req_ack` pulses once, and the following phases are 5 low / 5 high. `req_ready`=0 throughout PEND.
- Invalid request: `req_half`=0 in RUN -> `req_err` pulses for 1 cycle; `half`, waveform and `req_ack` are unchanged.
- Clean stop and restart: `run` drops mid high phase (`half`=4) -> the phase completes, `clk_out` ends at 0 and IDLE follows (`busy`=0). `run`=1 again -> first rise 4 cycles later.
- Simultaneous events:
  - Request plus `run`=0 in RUN -> new ratio applied, ack pulsed, then IDLE.
  - Request on the exact period-end edge -> ack at the following period end.
- Reset mid-PEND: assert `nreset` for 1 edge -> IDLE, `clk_out`=0, no `req_ack`, and `half` returns to `HALF_DEF`=1.
